vga_sync_gen: RTL and testbench

VGA timing generator, downstream of the pixel-clock divider. It is clocked by the divided pixel clock, optionally qualified by a pixel-tick enable. It produces hsync/vsync, the active-video flag, the current pixel coordinates, and frame/line strobes for the pixel renderer. Default timing is 640x480@60 (800x525 total).

---
 rtl/vga_sync_gen.sv | 120 ++++++++++++
 tb/tb_vga_sync_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: registered hsync/vsync, active-video flag, pixel coordinates and line/frame strobes.
// Define VGA_TEST_PATTERN_EN to add a registered 12-bit colour-bar output (rgb).
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        line_end,
    output logic        frame_start
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [11:0] rgb
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] h_cnt, v_cnt;
    logic       h_end, v_end;

    assign h_end = (h_cnt == H_LAST);
    assign v_end = (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            h_cnt <= h_end ? '0 : h_cnt + 10'd1;
            if (h_end)
                v_cnt <= v_end ? '0 : v_cnt + 10'd1;
        end
    end

    // Decode the pre-edge counter values so every output lands aligned with x/y.
    logic hsync_nxt, vsync_nxt, video_on_nxt, frame_start_nxt;

    always_comb begin
        hsync_nxt       = ((h_cnt >= HS_START) && (h_cnt <= HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_nxt       = ((v_cnt >= VS_START) && (v_cnt <= VS_END)) ? SYNC_POL : ~SYNC_POL;
        video_on_nxt    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        frame_start_nxt = (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            video_on    <= video_on_nxt;
            x           <= h_cnt;
            y           <= v_cnt;
            line_end    <= h_end;
            frame_start <= frame_start_nxt;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // Eight equal-width bars across the active area, white down to black.
    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

    logic [9:0]  bar_idx;
    logic [11:0] rgb_nxt;

    always_comb begin
        bar_idx = h_cnt / BAR_W;
        rgb_nxt = 12'h000;
        if (video_on_nxt) begin
            case (bar_idx[2:0])
                3'd0:    rgb_nxt = 12'hFFF;
                3'd1:    rgb_nxt = 12'hFF0;
                3'd2:    rgb_nxt = 12'h0FF;
                3'd3:    rgb_nxt = 12'h0F0;
                3'd4:    rgb_nxt = 12'hF0F;
                3'd5:    rgb_nxt = 12'hF00;
                3'd6:    rgb_nxt = 12'h00F;
                default: rgb_nxt = 12'h000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rgb <= 12'h000;
        else if (pix_en)
            rgb <= rgb_nxt;
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen using a reduced 48x27 timing so whole frames run quickly.
module tb_vga_sync_gen;
    localparam int HA = 32, HF = 4, HS = 8, HB = 4;
    localparam int VA = 20, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam bit POL = 1'b0;
    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                         12'hF0F, 12'hF00, 12'h00F, 12'h000};

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        von;
        logic        le;
        logic        fs;
        logic [11:0] rgb;
    } obs_t;

    typedef struct {
        int   k;
        int   x;
        int   y;
        logic hs, vs, von, le, fs;
    } vec_t;

    logic clk = 1'b0, reset = 1'b0, pix_en = 1'b0;
    logic hsync, vsync, video_on, line_end, frame_start;
    logic [9:0] x, y;
    logic [11:0] rgb_obs;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .x(x), .y(y), .line_end(line_end), .frame_start(frame_start)
`ifdef VGA_TEST_PATTERN_EN
        , .rgb(rgb_obs)
`endif
    );
`ifndef VGA_TEST_PATTERN_EN
    assign rgb_obs = 12'h000;
`endif

    always #5 clk = ~clk;

    int k = 0;        // pixel ticks accepted since the last reset release
    int errors = 0;
    int checks = 0;

    // Expected outputs after t ticks: tick t shows raster position t-1.
    function automatic obs_t model(input int t);
        obs_t o;
        int p, xi, yi;
        o = '0;
        o.hs = ~POL;
        o.vs = ~POL;
        if (t == 0) return o;
        p  = t - 1;
        xi = p % HT;
        yi = (p / HT) % VT;
        o.x   = 10'(xi);
        o.y   = 10'(yi);
        o.hs  = (xi >= HA + HF && xi < HA + HF + HS) ? POL : ~POL;
        o.vs  = (yi >= VA + VF && yi < VA + VF + VS) ? POL : ~POL;
        o.von = (xi < HA) && (yi < VA);
        o.le  = (xi == HT - 1);
        o.fs  = (xi == 0) && (yi == 0);
`ifdef VGA_TEST_PATTERN_EN
        if (o.von) o.rgb = BARS[xi / (HA / 8)];
`endif
        return o;
    endfunction

    function automatic obs_t actual();
        obs_t o;
        o = '{x, y, hsync, vsync, video_on, line_end, frame_start, rgb_obs};
        return o;
    endfunction

    task automatic check_model(input string name);
        obs_t a, e;
        a = actual();
        e = model(k);
        checks++;
        if (a !== e) begin
            errors++;
            if (errors < 20)
                $display("FAIL %s tick=%0d got x=%0d y=%0d hs=%b vs=%b von=%b le=%b fs=%b rgb=%h want x=%0d y=%0d hs=%b vs=%b von=%b le=%b fs=%b rgb=%h",
                         name, k, a.x, a.y, a.hs, a.vs, a.von, a.le, a.fs, a.rgb,
                         e.x, e.y, e.hs, e.vs, e.von, e.le, e.fs, e.rgb);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic cyc(input logic en);
        pix_en = en;
        @(posedge clk);
        if (reset && en) k++;
        @(negedge clk);
    endtask

    vec_t tab[$];
    int fs_last, vs_low, hs_low, n;

    initial begin
        // tick, x, y, hsync, vsync, video_on, line_end, frame_start
        tab.push_back('{1,     0,  0, 1, 1, 1, 0, 1});
        tab.push_back('{32,   31,  0, 1, 1, 1, 0, 0});
        tab.push_back('{33,   32,  0, 1, 1, 0, 0, 0});
        tab.push_back('{37,   36,  0, 0, 1, 0, 0, 0});
        tab.push_back('{44,   43,  0, 0, 1, 0, 0, 0});
        tab.push_back('{45,   44,  0, 1, 1, 0, 0, 0});
        tab.push_back('{48,   47,  0, 1, 1, 0, 1, 0});
        tab.push_back('{49,    0,  1, 1, 1, 1, 0, 0});
        tab.push_back('{961,   0, 20, 1, 1, 0, 0, 0});
        tab.push_back('{1057,  0, 22, 1, 0, 0, 0, 0});
        tab.push_back('{1152, 47, 23, 1, 0, 0, 1, 0});
        tab.push_back('{1153,  0, 24, 1, 1, 0, 0, 0});
        tab.push_back('{1296, 47, 26, 1, 1, 0, 1, 0});
        tab.push_back('{1297,  0,  0, 1, 1, 1, 0, 1});

        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1);
            check_model("reset_hold");
        end
        reset = 1'b1;

        foreach (tab[i]) begin
            while (k < tab[i].k) begin
                cyc(1'b1);
                check_model("run");
            end
            checks++;
            if ({x, y, hsync, vsync, video_on, line_end, frame_start} !==
                {10'(tab[i].x), 10'(tab[i].y), tab[i].hs, tab[i].vs, tab[i].von, tab[i].le, tab[i].fs}) begin
                errors++;
                $display("FAIL vec%0d tick=%0d got x=%0d y=%0d hs=%b vs=%b von=%b le=%b fs=%b want x=%0d y=%0d hs=%b vs=%b von=%b le=%b fs=%b",
                         i, k, x, y, hsync, vsync, video_on, line_end, frame_start,
                         tab[i].x, tab[i].y, tab[i].hs, tab[i].vs, tab[i].von, tab[i].le, tab[i].fs);
            end
        end

        // One whole frame: sync pulse lengths and frame_start period.
        fs_last = k;
        vs_low  = 0;
        hs_low  = 0;
        for (int i = 0; i < HT * VT; i++) begin
            cyc(1'b1);
            check_model("frame");
            if (vsync == POL) vs_low++;
            if (hsync == POL) hs_low++;
            if (frame_start) begin
                check_val("fs_period", k - fs_last, HT * VT);
                fs_last = k;
            end
        end
        check_val("vsync_low_ticks", vs_low, VS * HT);
        check_val("hsync_low_ticks", hs_low, HS * VT);
        check_val("fs_seen_at_end", fs_last, k);

        // Sparse pixel ticks: outputs must hold between ticks.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 3) == 0);
            check_model("sparse");
        end

        // Walk to (20,10), then pulse reset mid-cycle.
        n = 0;
        while (!(model(k).x == 10'd20 && model(k).y == 10'd10) && n < 5000) begin
            cyc(1'b1);
            check_model("seek");
            n++;
        end
        check_val("seek_timeout", n < 5000 ? 1 : 0, 1);
        #2 reset = 1'b0;
        k = 0;
        #1 check_model("async_reset");
        @(posedge clk);
        @(negedge clk);
        check_model("reset_after_edge");
        reset = 1'b1;
        cyc(1'b1);
        check_model("restart");
        check_val("restart_fs", int'(frame_start), 1);
        for (int i = 0; i < 200; i++) begin
            cyc($urandom_range(0, 1) == 1);
            check_model("post_reset");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
